hist_accum_bram: RTL

Per-frame 256-bin luma histogram builder that sits directly upstream of the CDF stage in the histogram-equalization path. Accepts one 8-bit pixel per cycle, accumulates bin counts in on-chip RAM with a read-modify-write pipeline, then streams the finished bins 0..255 in order as 16-bit counts to the CDF stage. Each bin is cleared as it is read out, so the next frame starts from zero.

---
 rtl/hist_pkg.sv | 19 +
 rtl/hist_ram_dp.sv | 25 ++
 rtl/hist_accum_bram.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/hist_pkg.sv
// Shared constants, types and state encoding for the luma histogram builder.
package hist_pkg;

  localparam int unsigned COUNT_W = 16;
  localparam int unsigned BINS    = 256;
  localparam int unsigned BIN_W   = 8;
  localparam int unsigned PTR_W   = BIN_W + 1;

  typedef logic [COUNT_W-1:0] count_t;
  typedef logic [BIN_W-1:0]   bin_t;

  typedef enum logic [1:0] {
    CLEAR,
    ACCUM,
    DRAIN,
    READOUT
  } state_e;

endpackage

// File: rtl/hist_ram_dp.sv
// Simple dual-port bin RAM: one write port, one read port with 1-cycle
// synchronous read. A read and write to the same address on the same edge
// returns the old contents; the parent forwards around that case.
module hist_ram_dp
  import hist_pkg::*;
(
  input  logic   clk,
  input  logic   we_i,
  input  bin_t   waddr_i,
  input  count_t wdata_i,
  input  bin_t   raddr_i,
  output count_t rdata_o
);

  count_t mem [BINS];

  // Storage write and registered read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/hist_accum_bram.sv
// Per-frame 256-bin luma histogram: CLEAR zeroes the RAM, ACCUM counts pixels
// through a read-modify-write pipeline with one-deep forwarding, DRAIN retires
// the last write, READOUT streams bins 0..255 and clears each one on accept.
// Optional feature macro: HIST_SATURATE_EN (saturating counts instead of wrap).
module hist_accum_bram
  import hist_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_valid,
  input  logic [BIN_W-1:0]   pix_data,
  input  logic               pix_frame_end,
  output logic               pix_ready,
  output logic               hist_valid,
  input  logic               hist_ready,
  output logic [BIN_W-1:0]   hist_bin,
  output logic [COUNT_W-1:0] hist_data,
  output logic               hist_last,
  output logic               busy
);

  state_e           state_q, state_d;
  bin_t             clr_q, clr_d;
  logic             drn_q, drn_d;
  logic             s0_vld_q, s0_vld_d;
  bin_t             s0_idx_q, s0_idx_d;
  logic             s1_vld_q, s1_vld_d;
  bin_t             s1_idx_q, s1_idx_d;
  count_t           s1_cnt_q, s1_cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             infl_q, infl_d;
  bin_t             infl_bin_q, infl_bin_d;
  logic             pf_vld_q, pf_vld_d;
  bin_t             pf_bin_q, pf_bin_d;
  count_t           pf_data_q, pf_data_d;
  logic             hv_q, hv_d;
  bin_t             hb_q, hb_d;
  count_t           hd_q, hd_d;
  logic             hl_q, hl_d;
  logic             pix_ready_q, pix_ready_d;
  logic             busy_q, busy_d;

  logic             ram_we;
  bin_t             ram_waddr;
  count_t           ram_wdata;
  bin_t             ram_raddr;
  count_t           ram_rdata;

  logic             accept;
  logic             pop;
  count_t           base;
  count_t           sum;
  logic [1:0]       occ;
  logic [1:0]       occ_after;

  hist_ram_dp u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Handshakes, forwarding select and the saturating/wrapping increment.
  always_comb begin
    accept    = pix_valid && pix_ready_q;
    pop       = hv_q && hist_ready;
    base      = (s1_vld_q && (s1_idx_q == s0_idx_q)) ? s1_cnt_q : ram_rdata;
`ifdef HIST_SATURATE_EN
    sum       = (base == '1) ? base : base + count_t'(1);
`else
    sum       = base + count_t'(1);
`endif
    occ       = {1'b0, hv_q} + {1'b0, pf_vld_q} + {1'b0, infl_q};
    occ_after = occ - {1'b0, pop};
  end

  // Next-state, RAM port muxing and readout buffer steering.
  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    drn_d       = drn_q;
    s0_vld_d    = accept;
    s0_idx_d    = accept ? pix_data : s0_idx_q;
    s1_vld_d    = s0_vld_q;
    s1_idx_d    = s0_idx_q;
    s1_cnt_d    = sum;
    rd_ptr_d    = rd_ptr_q;
    infl_d      = 1'b0;
    infl_bin_d  = infl_bin_q;
    pf_vld_d    = pf_vld_q;
    pf_bin_d    = pf_bin_q;
    pf_data_d   = pf_data_q;
    hv_d        = hv_q;
    hb_d        = hb_q;
    hd_d        = hd_q;
    ram_we      = s0_vld_q;
    ram_waddr   = s0_idx_q;
    ram_wdata   = sum;
    ram_raddr   = pix_data;

    unique case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_q;
        ram_wdata = '0;
        clr_d     = clr_q + 8'd1;
        if (clr_q == 8'(BINS - 1)) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept && pix_frame_end) begin
          state_d  = DRAIN;
          drn_d    = 1'b0;
          rd_ptr_d = '0;
        end
      end
      DRAIN: begin
        ram_raddr = rd_ptr_q[BIN_W-1:0];
        drn_d     = 1'b1;
        if (drn_q) begin
          infl_d     = 1'b1;
          infl_bin_d = rd_ptr_q[BIN_W-1:0];
          rd_ptr_d   = rd_ptr_q + 9'd1;
          state_d    = READOUT;
        end
      end
      READOUT: begin
        ram_we    = pop;
        ram_waddr = hb_q;
        ram_wdata = '0;
        ram_raddr = rd_ptr_q[BIN_W-1:0];
        if (!rd_ptr_q[PTR_W-1] && (occ_after < 2'd2)) begin
          infl_d     = 1'b1;
          infl_bin_d = rd_ptr_q[BIN_W-1:0];
          rd_ptr_d   = rd_ptr_q + 9'd1;
        end
        if (!hv_q || pop) begin
          if (pf_vld_q) begin
            hv_d      = 1'b1;
            hb_d      = pf_bin_q;
            hd_d      = pf_data_q;
            pf_vld_d  = infl_q;
            pf_bin_d  = infl_bin_q;
            pf_data_d = ram_rdata;
          end else if (infl_q) begin
            hv_d      = 1'b1;
            hb_d      = infl_bin_q;
            hd_d      = ram_rdata;
          end else begin
            hv_d      = 1'b0;
          end
        end else if (infl_q) begin
          pf_vld_d  = 1'b1;
          pf_bin_d  = infl_bin_q;
          pf_data_d = ram_rdata;
        end
        if (pop && hl_q) begin
          state_d = ACCUM;
        end
      end
      default: state_d = CLEAR;
    endcase

    hl_d        = hv_d && (hb_d == 8'(BINS - 1));
    pix_ready_d = (state_d == ACCUM);
    busy_d      = (state_d != ACCUM);
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CLEAR;
      clr_q       <= '0;
      drn_q       <= 1'b0;
      s0_vld_q    <= 1'b0;
      s0_idx_q    <= '0;
      s1_vld_q    <= 1'b0;
      s1_idx_q    <= '0;
      s1_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      infl_q      <= 1'b0;
      infl_bin_q  <= '0;
      pf_vld_q    <= 1'b0;
      pf_bin_q    <= '0;
      pf_data_q   <= '0;
      hv_q        <= 1'b0;
      hb_q        <= '0;
      hd_q        <= '0;
      hl_q        <= 1'b0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      drn_q       <= drn_d;
      s0_vld_q    <= s0_vld_d;
      s0_idx_q    <= s0_idx_d;
      s1_vld_q    <= s1_vld_d;
      s1_idx_q    <= s1_idx_d;
      s1_cnt_q    <= s1_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      infl_q      <= infl_d;
      infl_bin_q  <= infl_bin_d;
      pf_vld_q    <= pf_vld_d;
      pf_bin_q    <= pf_bin_d;
      pf_data_q   <= pf_data_d;
      hv_q        <= hv_d;
      hb_q        <= hb_d;
      hd_q        <= hd_d;
      hl_q        <= hl_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign hist_valid = hv_q;
  assign hist_bin   = hb_q;
  assign hist_data  = hd_q;
  assign hist_last  = hl_q;
  assign busy       = busy_q;

endmodule
